// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file and sequencer for the iterative
// multiplier and divider. It accepts MULT/DIV/MTHI/MTLO requests,
// issues single-cycle unit starts, and latches results into HI/LO.
// It reports completion, divide-by-zero, or a watchdog timeout.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        op_done,
  output logic        div_zero_exc,
  output logic        timeout_err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        mult_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_end,
  input  logic        mult_end,
  input  logic        div_zero
);

  typedef enum logic [2:0] {
    IDLE,
    START_DIV,
    WAIT_DIV,
    START_MULT,
    WAIT_MULT
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] hi_nxt, lo_nxt, a_nxt, b_nxt;
  logic        done_nxt, dz_nxt, to_nxt;

  // Status outputs decode directly from state.
  always_comb begin
    busy       = (state != IDLE);
    div_start  = (state == START_DIV);
    mult_start = (state == START_MULT);
  end

  // Next-state, register-update and completion-pulse logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    a_nxt     = unit_a;
    b_nxt     = unit_b;
    done_nxt  = 1'b0;
    dz_nxt    = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            2'b00: begin
              a_nxt     = rs_val;
              b_nxt     = rt_val;
              state_nxt = START_MULT;
            end
            2'b01: begin
              a_nxt     = rs_val;
              b_nxt     = rt_val;
              state_nxt = START_DIV;
            end
            2'b10: begin
              hi_nxt   = rs_val;
              done_nxt = 1'b1;
            end
            default: begin
              lo_nxt   = rs_val;
              done_nxt = 1'b1;
            end
          endcase
        end
      end
      START_DIV: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_DIV;
      end
      WAIT_DIV: begin
        cnt_nxt = cnt + 8'd1;
        if (div_zero) begin
          dz_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (div_end) begin
          hi_nxt    = div_hi;
          lo_nxt    = div_lo;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LAST_CNT) begin
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      START_MULT: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_MULT;
      end
      WAIT_MULT: begin
        cnt_nxt = cnt + 8'd1;
        if (mult_end) begin
          hi_nxt    = mult_hi;
          lo_nxt    = mult_lo;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LAST_CNT) begin
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, HI/LO, operand and pulse registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      unit_a       <= '0;
      unit_b       <= '0;
      op_done      <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hi           <= hi_nxt;
      lo           <= lo_nxt;
      unit_a       <= a_nxt;
      unit_b       <= b_nxt;
      op_done      <= done_nxt;
      div_zero_exc <= dz_nxt;
      timeout_err  <= to_nxt;
    end
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle arithmetic sequencer and HI/LO register file for the multicycle CPU datapath. Sits between the control unit and the iterative divider/multiplier blocks. It accepts a MULT/DIV/MTHI/MTLO request, issues a single-cycle start to the selected unit, and holds operands stable while the unit runs. On completion it latches the unit's Hi/Lo results into the architectural HI/LO registers, and reports completion, divide-by-zero or watchdog timeout to the control unit.

## Interface
- TIMEOUT, 64: maximum cycles spent in a WAIT state before a timeout error is raised; legal range 2..255.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  request strobe; sampled only in IDLE
- op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- rs_val  in  32  operand A / MTHI-MTLO source
- rt_val  in  32  operand B
- busy  out  1  high whenever state != IDLE (control unit stalls)
- op_done  out  1  one-cycle pulse: HI/LO updated
- div_zero_exc  out  1  one-cycle pulse: DIV aborted, divisor zero
- timeout_err  out  1  one-cycle pulse: unit never finished
- hi, lo  out  32  architectural HI/LO registers
- div_start, mult_start  out  1  one-cycle start pulses
- unit_a, unit_b  out  32  latched operands, shared by both units
- div_hi, div_lo, mult_hi, mult_lo  in  32  unit results
- div_end, mult_end, div_zero  in  1  unit status

## Operation
- States: IDLE, START_DIV, WAIT_DIV, START_MULT, WAIT_MULT.
- IDLE, op_valid=1:
  - MULT/DIV: latch rs_val/rt_val into unit_a/unit_b, go to START_MULT/START_DIV.
  - MTHI/MTLO: write rs_val to hi/lo at that edge, op_done=1 next cycle, remain in IDLE.
- START_x: the matching start output is 1 for exactly this cycle. Next state is WAIT_x, with the watchdog counter cleared to 0.
- WAIT_x: counter increments each cycle. Priority per cycle, highest first:
  1. WAIT_DIV with div_zero=1: hi/lo unchanged, div_zero_exc pulse, go to IDLE.
  2. The matching end input is 1: hi<=x_hi, lo<=x_lo, op_done pulse, go to IDLE.
  3. Counter == TIMEOUT-1: timeout_err pulse, hi/lo unchanged, go to IDLE.
- The end input of the non-selected unit is ignored. All end/zero inputs are ignored in IDLE and START states.
- unit_a/unit_b change only on acceptance in IDLE and hold until the next accepted MULT/DIV.
- op_valid while busy is ignored. The control unit must re-present the request after busy falls.
- Units report signed results: DIV gives quotient in lo (truncated toward zero) and remainder in hi (sign of dividend). MULT gives a 64-bit product, {hi,lo}. This block performs no arithmetic on them.

## Timing
- Reset (wins over everything, any state):
  - state IDLE
  - hi=lo=0, unit_a=unit_b=0
  - busy, op_done, div_zero_exc, timeout_err, div_start, mult_start all 0
  - counter 0
- Reset mid-operation: the in-flight result is discarded and no pulse is generated. Units share the same reset.
- op_done, div_zero_exc and timeout_err are registered and mutually exclusive. Each is high exactly one cycle, in the first IDLE cycle after the event edge. hi/lo hold their new values in that same cycle.
- busy is combinational from state. It rises the cycle after acceptance and falls in the same cycle the completion pulse is high.
- DIV latency, with op_valid in cycle 0:
  - div_start in cycle 1
  - the divider's 32-iteration run places div_end in cycle 34
  - op_done and new hi/lo in cycle 35
- DIV by zero: div_zero in cycle 2, div_zero_exc in cycle 3.
- MTHI/MTLO: op_done the cycle after the request, and busy never asserts.
- A new request may be accepted in the same cycle op_done is high.

## Test plan
- Reset, then DIV rs=7 rt=0xFFFFFFFE against the real divider -> op_done in cycle 35; lo=0xFFFFFFFD, hi=0x00000001; div_start high exactly cycle 1.
- DIV rs=100 rt=0 -> div_zero_exc in cycle 3; hi/lo keep their prior values; op_done never pulses; busy low from cycle 3.
- MULT rs=0xFFFFFFFF rt=3 with a 4-cycle multiplier model -> hi=0xFFFFFFFF, lo=0xFFFFFFFD; op_done once; mult_start single pulse.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 back-to-back -> hi=0xDEADBEEF, lo=0x12345678; op_done in two consecutive cycles; busy stays 0.
- TIMEOUT=8, with a MULT model that never asserts mult_end -> timeout_err 9 cycles after mult_start; hi/lo unchanged; the next MTLO is accepted normally.
- Reset asserted in cycle 10 of a DIV, and op_valid pulses during busy -> all outputs are at reset values the next cycle; no op_done; requests issued while busy are dropped.
